// File: rtl/axi_ax_snoop_fifo.sv
// rtl/axi_ax_snoop_fifo.sv - transparent AXI Ax channel tap buffering each handshake as a multi-beat stream record
module axi_ax_snoop_fifo #(
    parameter int ADDR_WIDTH        = 64,
    parameter int ID_WIDTH          = 32,
    parameter int BURST_LEN         = 8,
    parameter int LOCK_WIDTH        = 2,
    parameter int USER_WIDTH        = 64,
    parameter int STREAM_WIDTH      = 64,
    parameter int FIFO_DEPTH        = 4,
    parameter bit BLOCK_ON_FULL     = 1'b1,
    parameter int STREAM_TYPE_WIDTH = 3,
    parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = '0,
    parameter int DROP_CNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ready,
    output logic                          valid,
    output logic                          in_progress,
    output logic                          last,
    output logic [STREAM_WIDTH-1:0]       data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [DROP_CNT_WIDTH-1:0]     drop_count,
    input  logic [ID_WIDTH-1:0]           AXIS_axid,
    input  logic [ADDR_WIDTH-1:0]         AXIS_axaddr,
    input  logic [BURST_LEN-1:0]          AXIS_axlen,
    input  logic [2:0]                    AXIS_axsize,
    input  logic [1:0]                    AXIS_axburst,
    input  logic [LOCK_WIDTH-1:0]         AXIS_axlock,
    input  logic [3:0]                    AXIS_axcache,
    input  logic [2:0]                    AXIS_axprot,
    input  logic [3:0]                    AXIS_axregion,
    input  logic [3:0]                    AXIS_axqos,
    input  logic [USER_WIDTH-1:0]         AXIS_axuser,
    input  logic                          AXIS_axvalid,
    output logic                          AXIS_axready,
    output logic [ID_WIDTH-1:0]           AXIM_axid,
    output logic [ADDR_WIDTH-1:0]         AXIM_axaddr,
    output logic [BURST_LEN-1:0]          AXIM_axlen,
    output logic [2:0]                    AXIM_axsize,
    output logic [1:0]                    AXIM_axburst,
    output logic [LOCK_WIDTH-1:0]         AXIM_axlock,
    output logic [3:0]                    AXIM_axcache,
    output logic [2:0]                    AXIM_axprot,
    output logic [3:0]                    AXIM_axregion,
    output logic [3:0]                    AXIM_axqos,
    output logic [USER_WIDTH-1:0]         AXIM_axuser,
    output logic                          AXIM_axvalid,
    input  logic                          AXIM_axready
);

    localparam int HDR_W  = STREAM_TYPE_WIDTH + ID_WIDTH + BURST_LEN + 5;
    localparam int BEATS  = (HDR_W + ADDR_WIDTH + STREAM_WIDTH - 1) / STREAM_WIDTH;
    localparam int REC_W  = BEATS * STREAM_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t              state;
    logic [BIDX_W-1:0]   bidx;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [REC_W-1:0]    mem [FIFO_DEPTH];
    logic [REC_W-1:0]    head;
    logic [REC_W-1:0]    rec_new;
    logic [HDR_W-1:0]    hdr;
    logic                full;
    logic                push;
    logic                pop;
    logic                beat_fire;
    logic                is_last_beat;
    logic                drop_evt;

    assign AXIM_axid     = AXIS_axid;
    assign AXIM_axaddr   = AXIS_axaddr;
    assign AXIM_axlen    = AXIS_axlen;
    assign AXIM_axsize   = AXIS_axsize;
    assign AXIM_axburst  = AXIS_axburst;
    assign AXIM_axlock   = AXIS_axlock;
    assign AXIM_axcache  = AXIS_axcache;
    assign AXIM_axprot   = AXIS_axprot;
    assign AXIM_axregion = AXIS_axregion;
    assign AXIM_axqos    = AXIS_axqos;
    assign AXIM_axuser   = AXIS_axuser;

    // Full is taken from the registered count, so a pop never makes room for a same-cycle push
    assign full = (count == CNT_W'(FIFO_DEPTH));

    assign AXIM_axvalid = BLOCK_ON_FULL ? (AXIS_axvalid & ~full) : AXIS_axvalid;
    assign AXIS_axready = BLOCK_ON_FULL ? (AXIM_axready & ~full) : AXIM_axready;

    assign push     = AXIM_axvalid & AXIM_axready & ~full & ~reset;
    assign drop_evt = ~BLOCK_ON_FULL & AXIS_axvalid & AXIM_axready & full;

    // Header sits at the MSB end so beat 0 carries the tag; the gap above addr is zero
    assign hdr     = {STREAM_TYPE, AXIS_axid, AXIS_axlen, AXIS_axsize, AXIS_axburst};
    assign rec_new = (REC_W'(hdr) << (REC_W - HDR_W)) | REC_W'(AXIS_axaddr);

    assign head         = mem[rd_ptr];
    assign is_last_beat = (bidx == BIDX_W'(BEATS - 1));
    assign valid        = ~reset & ((state == S_SEND) | (count != '0));
    assign in_progress  = ~reset & (state == S_SEND);
    assign last         = valid & is_last_beat;
    assign data         = STREAM_WIDTH'(head >> (STREAM_WIDTH * (BEATS - 1 - int'(bidx))));
    assign beat_fire    = valid & ready;
    assign pop          = beat_fire & is_last_beat;
    assign fifo_count   = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rec_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            bidx       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            if (drop_evt && (drop_count != '1)) begin
                drop_count <= drop_count + DROP_CNT_WIDTH'(1);
            end

            case (state)
                S_IDLE: begin
                    if (beat_fire && (BEATS > 1)) begin
                        state <= S_SEND;
                        bidx  <= BIDX_W'(1);
                    end
                end
                S_SEND: begin
                    if (beat_fire) begin
                        if (is_last_beat) begin
                            state <= S_IDLE;
                            bidx  <= '0;
                        end else begin
                            bidx <= bidx + BIDX_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    bidx  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ax_snoop_fifo.sv
// tb/tb_axi_ax_snoop_fifo.sv - randomized bench comparing a blocking and a dropping tap against a queue model
module tb_axi_ax_snoop_fifo;

    localparam int DEPTH = 4;
    localparam int BEATS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ready, s_valid, m_ready;
    logic [31:0] s_id;
    logic [63:0] s_addr, s_user;
    logic [7:0]  s_len;
    logic [2:0]  s_size, s_prot;
    logic [1:0]  s_burst, s_lock;
    logic [3:0]  s_cache, s_region, s_qos;

    logic        o_valid [2], o_inprog [2], o_last [2], o_sready [2], o_mvalid [2];
    logic [63:0] o_data [2];
    logic [2:0]  o_cnt [2];
    logic [15:0] o_drop [2];
    logic [31:0] m_id [2];
    logic [63:0] m_addr [2], m_user [2];
    logic [7:0]  m_len [2];
    logic [2:0]  m_size [2], m_prot [2];
    logic [1:0]  m_burst [2], m_lock [2];
    logic [3:0]  m_cache [2], m_region [2], m_qos [2];

    // Instance 0 blocks AXI when full; instance 1 passes through and counts drops in a narrow counter
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int DW = (g == 0) ? 16 : 4;
        logic [DW-1:0] dc;
        assign o_drop[g] = 16'(dc);
        axi_ax_snoop_fifo #(
            .BLOCK_ON_FULL (g == 0),
            .DROP_CNT_WIDTH(DW)
        ) dut (
            .clk(clk), .reset(reset), .ready(ready),
            .valid(o_valid[g]), .in_progress(o_inprog[g]), .last(o_last[g]), .data(o_data[g]),
            .fifo_count(o_cnt[g]), .drop_count(dc),
            .AXIS_axid(s_id), .AXIS_axaddr(s_addr), .AXIS_axlen(s_len), .AXIS_axsize(s_size),
            .AXIS_axburst(s_burst), .AXIS_axlock(s_lock), .AXIS_axcache(s_cache), .AXIS_axprot(s_prot),
            .AXIS_axregion(s_region), .AXIS_axqos(s_qos), .AXIS_axuser(s_user),
            .AXIS_axvalid(s_valid), .AXIS_axready(o_sready[g]),
            .AXIM_axid(m_id[g]), .AXIM_axaddr(m_addr[g]), .AXIM_axlen(m_len[g]), .AXIM_axsize(m_size[g]),
            .AXIM_axburst(m_burst[g]), .AXIM_axlock(m_lock[g]), .AXIM_axcache(m_cache[g]), .AXIM_axprot(m_prot[g]),
            .AXIM_axregion(m_region[g]), .AXIM_axqos(m_qos[g]), .AXIM_axuser(m_user[g]),
            .AXIM_axvalid(o_mvalid[g]), .AXIM_axready(m_ready)
        );
    end

    int vectors = 0;
    int miscompares = 0;

    logic [127:0] mq [2][$];
    int           bidx_m [2];
    int           drop_m [2];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] rec_of();
        return {3'b000, s_id, s_len, s_size, s_burst, 16'h0000, s_addr};
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            int           n    = mq[i].size();
            bit           full = (n == DEPTH);
            bit           blk  = (i == 0);
            bit           ev   = !reset && (n != 0);
            string        t    = blk ? "blk_" : "drp_";
            logic [127:0] head;
            head = (n != 0) ? mq[i][0] : '0;
            chk({t, "valid"}, o_valid[i], ev);
            chk({t, "last"}, o_last[i], ev && (bidx_m[i] == BEATS - 1));
            chk({t, "in_progress"}, o_inprog[i], !reset && (bidx_m[i] != 0));
            if (ev) chk({t, "data"}, o_data[i], (bidx_m[i] == 0) ? head[127:64] : head[63:0]);
            chk({t, "fifo_count"}, o_cnt[i], n);
            chk({t, "drop_count"}, o_drop[i], drop_m[i]);
            chk({t, "axis_ready"}, o_sready[i], blk ? (m_ready && !full) : m_ready);
            chk({t, "axim_valid"}, o_mvalid[i], blk ? (s_valid && !full) : s_valid);
            chk({t, "passthrough"},
                {m_id[i], m_addr[i], m_len[i], m_size[i], m_burst[i], m_lock[i], m_cache[i],
                 m_prot[i], m_region[i], m_qos[i], m_user[i]},
                {s_id, s_addr, s_len, s_size, s_burst, s_lock, s_cache, s_prot, s_region, s_qos, s_user});
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            int n    = mq[i].size();
            bit full = (n == DEPTH);
            int dmax = (i == 0) ? 65535 : 15;
            if (reset) begin
                mq[i].delete();
                bidx_m[i] = 0;
                drop_m[i] = 0;
            end else begin
                if (n != 0 && ready) begin
                    if (bidx_m[i] == BEATS - 1) begin
                        void'(mq[i].pop_front());
                        bidx_m[i] = 0;
                    end else begin
                        bidx_m[i]++;
                    end
                end
                if (s_valid && m_ready) begin
                    if (!full) mq[i].push_back(rec_of());
                    else if (i == 1 && drop_m[i] < dmax) drop_m[i]++;
                end
            end
        end
    endtask

    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic rand_fields();
        s_id     = $urandom;
        s_addr   = {$urandom, $urandom};
        s_user   = {$urandom, $urandom};
        s_len    = 8'($urandom);
        s_size   = 3'($urandom);
        s_burst  = 2'($urandom);
        s_lock   = 2'($urandom);
        s_cache  = 4'($urandom);
        s_prot   = 3'($urandom);
        s_region = 4'($urandom);
        s_qos    = 4'($urandom);
    endtask

    task automatic rand_cycle(input int p_valid, input int p_ready, input int p_mready);
        rand_fields();
        s_valid = ($urandom_range(99) < p_valid);
        ready   = ($urandom_range(99) < p_ready);
        m_ready = ($urandom_range(99) < p_mready);
        reset   = ($urandom_range(199) == 0);
        step();
    endtask

    initial begin
        reset = 1'b1; ready = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        rand_fields();
        for (int i = 0; i < 2; i++) begin
            bidx_m[i] = 0;
            drop_m[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Single AW record with known field values
        reset = 1'b0;
        s_id = 32'h5; s_addr = 64'h1000_0000; s_len = 8'd3; s_size = 3'd3; s_burst = 2'd1;
        s_valid = 1'b1; m_ready = 1'b1; ready = 1'b1;
        step();
        s_valid = 1'b0;
        #1;
        chk("t1_beat0", o_data[0], 64'h0000_0000_A06D_0000);
        chk("t1_last0", o_last[0], 1'b0);
        step();
        #1;
        chk("t1_beat1", o_data[0], 64'h0000_0000_1000_0000);
        chk("t1_last1", o_last[0], 1'b1);
        step();

        // Five back-to-back requests with the stream stalled
        reset = 1'b1;
        step();
        reset = 1'b0; ready = 1'b0; m_ready = 1'b1; s_valid = 1'b1;
        repeat (5) begin
            rand_fields();
            step();
        end
        #1;
        chk("t2_count", o_cnt[0], 3'd4);
        chk("t2_axis_ready", o_sready[0], 1'b0);
        chk("t3_count", o_cnt[1], 3'd4);
        chk("t3_drop", o_drop[1], 16'd1);

        // Drain one record while a push is held off until the registered count drops
        ready = 1'b1;
        step();
        rand_fields();
        #1;
        chk("t5_blocked", o_sready[0], 1'b0);
        step();
        rand_fields();
        #1;
        chk("t5_accept", o_sready[0], 1'b1);
        step();
        s_valid = 1'b0; ready = 1'b0;
        #1;
        chk("t5_count", o_cnt[0], 3'd4);
        step();

        // Saturate the narrow drop counter
        s_valid = 1'b1;
        repeat (20) begin
            rand_fields();
            step();
        end
        s_valid = 1'b0;
        #1;
        chk("t3_sat", o_drop[1], 16'd15);

        // Stall toggling mid-record
        ready = 1'b1; step();
        ready = 1'b0; step();
        ready = 1'b0; step();
        ready = 1'b1; step();

        // Reset after beat 0 with records queued
        ready = 1'b1; step();
        ready = 1'b0; reset = 1'b1;
        #1;
        chk("t6_valid_in_reset", o_valid[0], 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk("t6_count", o_cnt[0], 3'd0);
        chk("t6_inprog", o_inprog[0], 1'b0);
        rand_fields();
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        #1;
        chk("t6_restart_inprog", o_inprog[0], 1'b0);
        chk("t6_restart_valid", o_valid[0], 1'b1);
        step();

        // Randomized traffic with varying pressure on each side
        repeat (700) rand_cycle(50, 70, 80);
        repeat (700) rand_cycle(80, 25, 90);
        repeat (700) rand_cycle(30, 90, 50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
